// File: rtl/cpu_pkg.sv
// Shared definitions for the program-RAM loader.
//   state_t        : loader FSM states
//   HEADER_DEFAULT : default frame start byte
//   RAM_DEPTH      : number of program-RAM entries
//   ADDR_W         : program-RAM address width
//   count_ok()     : legal frame length test (1..RAM_DEPTH)
package cpu_pkg;

  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned RAM_DEPTH      = 16;
  localparam int unsigned ADDR_W         = 4;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    DONE
  } state_t;

  function automatic logic count_ok(input logic [7:0] n);
    return (n != 8'd0) && (n <= 8'(RAM_DEPTH));
  endfunction

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte idle timeout for the loader.
//   clk, rst : clock, synchronous active-high reset
//   enable   : count idle cycles while high (held cleared while low)
//   restart  : a byte was accepted this cycle; restart the count
//   expired  : TIMEOUT_CYCLES consecutive idle cycles have elapsed
module loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 300000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  // cnt holds the number of idle cycles already completed; the cycle seen
  // with cnt == LAST is the TIMEOUT_CYCLES-th idle one.
  always_ff @(posedge clk) begin
    if (rst || restart || !enable) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = enable && !restart && (cnt == LAST);

endmodule

// File: rtl/ram_loader.sv
// Byte-stream loader for a 16-entry program RAM.
// Frame: HEADER, N (1..16), N data bytes [, checksum byte].
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing mod-256
// checksum byte checked in the CHECK state.
//   clk, rst          : clock, synchronous active-high reset
//   rx_data, rx_valid : incoming byte stream
//   rx_ready          : loader can accept (low only in DONE)
//   ram_we            : one-cycle RAM write strobe
//   ram_addr          : RAM write address
//   ram_wdata         : RAM write data
//   cpu_halt          : holds the CPU while a load is pending or failed
//   load_done         : one-cycle pulse on a successful load
//   load_error        : sticky failure flag, cleared by the next header
module ram_loader
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 300000,
  parameter logic [7:0]  HEADER         = HEADER_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              cpu_halt,
  output logic              load_done,
  output logic              load_error
);

  state_t            state;
  logic [4:0]        count;
  logic [ADDR_W-1:0] idx;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        sum;
`endif

  logic accept;
  logic in_frame;
  logic last;
  logic expired;

  assign rx_ready = (state != DONE);
  assign accept   = rx_valid && rx_ready;
  assign in_frame = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign last     = ({1'b0, idx} == (count - 5'd1));

  loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .enable (in_frame),
    .restart(accept),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      idx        <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_halt   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      load_done <= 1'b0;
      // cpu_halt is left set on every error path: RAM may be partial.
      if (expired) begin
        load_error <= 1'b1;
        state      <= IDLE;
      end else begin
        unique case (state)
          IDLE: begin
            if (accept && rx_data == HEADER) begin
              state      <= COUNT;
              cpu_halt   <= 1'b1;
              load_error <= 1'b0;
            end
          end
          COUNT: begin
            if (accept) begin
              if (count_ok(rx_data)) begin
                count <= rx_data[4:0];
                idx   <= '0;
`ifdef LOADER_CHECKSUM_EN
                sum   <= '0;
`endif
                state <= DATA;
              end else begin
                load_error <= 1'b1;
                state      <= IDLE;
              end
            end
          end
          DATA: begin
            if (accept) begin
              ram_we    <= 1'b1;
              ram_addr  <= idx;
              ram_wdata <= rx_data;
`ifdef LOADER_CHECKSUM_EN
              sum       <= sum + rx_data;
`endif
              if (last) begin
`ifdef LOADER_CHECKSUM_EN
                state     <= CHECK;
`else
                state     <= DONE;
                load_done <= 1'b1;
                cpu_halt  <= 1'b0;
`endif
              end else begin
                idx <= idx + ADDR_W'(1);
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            if (accept) begin
              if (rx_data == sum) begin
                state     <= DONE;
                load_done <= 1'b1;
                cpu_halt  <= 1'b0;
              end else begin
                load_error <= 1'b1;
                state      <= IDLE;
              end
            end
          end
`endif
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader (timeout shortened to 20).
module tb_ram_loader;

  logic       clk;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       cpu_halt;
  logic       load_done;
  logic       load_error;

  int passed = 0;
  int total  = 0;

  // Write / done log, filled only by the monitor below.
  int         cyc = 0;
  int         wr_count = 0;
  int         done_count = 0;
  logic [3:0] wr_addr [128];
  logic [7:0] wr_data [128];
  int         wr_cyc  [128];

  ram_loader #(
    .TIMEOUT_CYCLES(20),
    .HEADER        (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .cpu_halt  (cpu_halt),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we && wr_count < 128) begin
      wr_addr[wr_count] = ram_addr;
      wr_data[wr_count] = ram_wdata;
      wr_cyc[wr_count]  = cyc;
      wr_count          = wr_count + 1;
    end
    if (load_done) done_count = done_count + 1;
  end

  // Present one byte for exactly one cycle; returns 1 time unit after the edge.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    idle(3);
    total++;
    if ({ram_we, ram_addr, ram_wdata, cpu_halt, load_done, load_error} !== 16'h0)
      $display("FAIL reset_outputs got %h want 0000",
               {ram_we, ram_addr, ram_wdata, cpu_halt, load_done, load_error});
    else passed++;
    total++;
    if (rx_ready !== 1'b1) $display("FAIL reset_rx_ready got %b want 1", rx_ready);
    else passed++;
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_discard;
    int base;
    base = wr_count;
    send(8'h00);
    send(8'hFF);
    idle(2);
    total++;
    if (wr_count - base !== 0) $display("FAIL discard_writes got %0d want 0", wr_count - base);
    else passed++;
    total++;
    if (cpu_halt !== 1'b0) $display("FAIL discard_halt got %b want 0", cpu_halt);
    else passed++;
  endtask

  task automatic test_basic_load;
    int base;
    int dbase;
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
    base = wr_count;
    dbase = done_count;
    send(8'hA5);
    total++;
    if (cpu_halt !== 1'b1) $display("FAIL basic_halt_set got %b want 1", cpu_halt);
    else passed++;
    send(8'h03);
    send(8'h11);
    send(8'h22);
    send(8'h33);
`ifdef LOADER_CHECKSUM_EN
    send(8'h66);
`endif
    // Now in DONE: pulse visible, halt released, not ready.
    total++;
    if ({load_done, cpu_halt, rx_ready} !== 3'b100)
      $display("FAIL basic_done_state got %b want 100", {load_done, cpu_halt, rx_ready});
    else passed++;
    idle(3);
    total++;
    if (wr_count - base !== 3) $display("FAIL basic_write_count got %0d want 3", wr_count - base);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      total++;
      if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== exp_d[i])
        $display("FAIL basic_write%0d got %h=%h want %h=%h", i, wr_addr[base+i],
                 wr_data[base+i], 4'(i), exp_d[i]);
      else passed++;
    end
    total++;
    if (wr_cyc[base+1] !== wr_cyc[base] + 1 || wr_cyc[base+2] !== wr_cyc[base] + 2)
      $display("FAIL basic_consecutive got %0d,%0d,%0d want consecutive", wr_cyc[base],
               wr_cyc[base+1], wr_cyc[base+2]);
    else passed++;
    total++;
    if (done_count - dbase !== 1) $display("FAIL basic_done_pulses got %0d want 1",
                                           done_count - dbase);
    else passed++;
    total++;
    if ({cpu_halt, load_error} !== 2'b00)
      $display("FAIL basic_final_flags got %b want 00", {cpu_halt, load_error});
    else passed++;
  endtask

  task automatic test_bad_count;
    int base;
    base = wr_count;
    send(8'hA5);
    send(8'h00);
    total++;
    if ({load_error, cpu_halt} !== 2'b11)
      $display("FAIL count_zero got err,halt=%b want 11", {load_error, cpu_halt});
    else passed++;
    send(8'hA5);
    total++;
    if (load_error !== 1'b0) $display("FAIL header_clears_error got %b want 0", load_error);
    else passed++;
    send(8'h11);
    total++;
    if (load_error !== 1'b1) $display("FAIL count_17 got %b want 1", load_error);
    else passed++;
    // Back in IDLE: a data-looking byte must not produce a write.
    send(8'h01);
    idle(2);
    total++;
    if (wr_count - base !== 0) $display("FAIL bad_count_writes got %0d want 0", wr_count - base);
    else passed++;
  endtask

  task automatic test_timeout;
    int base;
    base = wr_count;
    send(8'hA5);
    send(8'h04);
    send(8'h01);
    idle(19);
    total++;
    if (load_error !== 1'b0) $display("FAIL timeout_early got %b want 0", load_error);
    else passed++;
    idle(1);
    total++;
    if ({load_error, cpu_halt} !== 2'b11)
      $display("FAIL timeout_expire got err,halt=%b want 11", {load_error, cpu_halt});
    else passed++;
    total++;
    if (wr_count - base !== 1) $display("FAIL timeout_writes got %0d want 1", wr_count - base);
    else passed++;
  endtask

  task automatic test_reset_midframe;
    int base;
    send(8'hA5);
    send(8'h04);
    send(8'h01);
    rst = 1'b1;
    idle(1);
    total++;
    if ({ram_we, ram_addr, ram_wdata, cpu_halt, load_done, load_error} !== 16'h0)
      $display("FAIL midframe_reset got %h want 0000",
               {ram_we, ram_addr, ram_wdata, cpu_halt, load_done, load_error});
    else passed++;
    rst = 1'b0;
    idle(1);
    base = wr_count;
    send(8'hA5);
    send(8'h01);
    send(8'h7F);
`ifdef LOADER_CHECKSUM_EN
    send(8'h7F);
`endif
    idle(2);
    total++;
    if (wr_count - base !== 1 || wr_addr[base] !== 4'h0 || wr_data[base] !== 8'h7F)
      $display("FAIL reload_after_reset got n=%0d %h=%h want n=1 0=7f", wr_count - base,
               wr_addr[base], wr_data[base]);
    else passed++;
    total++;
    if (cpu_halt !== 1'b0) $display("FAIL reload_halt got %b want 0", cpu_halt);
    else passed++;
  endtask

  // Full 16-byte frame, payload includes a header byte.
  task automatic test_back_to_back;
    int base;
    int dbase;
    logic [7:0] d [16];
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < 16; i++) begin
      d[i] = (i == 5) ? 8'hA5 : 8'(i * 17 + 3);
      s = s + d[i];
    end
    base = wr_count;
    dbase = done_count;
    send(8'hA5);
    send(8'h10);
    for (int i = 0; i < 16; i++) send(d[i]);
`ifdef LOADER_CHECKSUM_EN
    send(s);
`endif
    idle(3);
    total++;
    if (wr_count - base !== 16) $display("FAIL full_write_count got %0d want 16", wr_count - base);
    else passed++;
    for (int i = 0; i < 16; i++) begin
      total++;
      if (wr_addr[base+i] !== 4'(i) || wr_data[base+i] !== d[i] ||
          wr_cyc[base+i] !== wr_cyc[base] + i)
        $display("FAIL full_write%0d got %h=%h want %h=%h", i, wr_addr[base+i],
                 wr_data[base+i], 4'(i), d[i]);
      else passed++;
    end
    total++;
    if (done_count - dbase !== 1 || cpu_halt !== 1'b0 || load_error !== 1'b0)
      $display("FAIL full_done got done=%0d halt=%b err=%b want 1 0 0", done_count - dbase,
               cpu_halt, load_error);
    else passed++;
  endtask

`ifdef LOADER_CHECKSUM_EN
  task automatic test_checksum;
    int base;
    int dbase;
    base = wr_count;
    dbase = done_count;
    send(8'hA5);
    send(8'h02);
    send(8'h10);
    send(8'h20);
    send(8'h30);
    idle(2);
    total++;
    if (wr_count - base !== 2 || done_count - dbase !== 1)
      $display("FAIL cksum_good got w=%0d d=%0d want 2 1", wr_count - base, done_count - dbase);
    else passed++;
    dbase = done_count;
    send(8'hA5);
    send(8'h02);
    send(8'h10);
    send(8'h20);
    send(8'h31);
    idle(2);
    total++;
    if ({load_error, cpu_halt} !== 2'b11 || done_count - dbase !== 0)
      $display("FAIL cksum_bad got err,halt=%b d=%0d want 11 0", {load_error, cpu_halt},
               done_count - dbase);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_discard();
    test_basic_load();
    test_bad_count();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
`ifdef LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_loader.md
RAM_LOADER -- requirements
Module: ram_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 300000, SHALL set the maximum idle clk cycles allowed between accepted bytes inside a frame.
REQ-002 Parameter HEADER, default 8'hA5, SHALL set the frame start byte.
REQ-003 Port clk  in  1  SHALL be the single clock; all logic rising-edge.
REQ-004 Port rst  in  1  SHALL be the synchronous, active-high reset.
REQ-005 Port rx_data  in  8  SHALL be the incoming byte.
REQ-006 Port rx_valid  in  1  SHALL mark rx_data valid.
REQ-007 Port rx_ready  out  1  SHALL mark the loader able to accept; a byte transfers on a cycle with rx_valid && rx_ready.
REQ-008 Port ram_we  out  1  SHALL be a one-cycle program-RAM write strobe.
REQ-009 Port ram_addr  out  4  SHALL be the write address (16-entry RAM).
REQ-010 Port ram_wdata  out  8  SHALL be the write data.
REQ-011 Port cpu_halt  out  1  SHALL hold the CPU step counter and PC while high.
REQ-012 Port load_done  out  1  SHALL pulse for one cycle on a successful load.
REQ-013 Port load_error  out  1  SHALL be a sticky failure flag.

Function
REQ-014 FSM states SHALL be IDLE, COUNT, DATA, CHECK, DONE.
REQ-015 rx_ready SHALL be 1 in IDLE, COUNT, DATA, CHECK and 0 in DONE.
REQ-016 IDLE: accepted byte == HEADER -> COUNT, set cpu_halt, clear load_error; any other byte discarded, no state change.
REQ-017 COUNT: accepted byte N with 1 <= N <= 16 -> latch N, clear address and checksum, go DATA; N == 0 or N > 16 -> set load_error, go IDLE.
REQ-018 DATA: each accepted byte SHALL produce ram_we=1 on the next cycle with ram_addr = byte index (0..N-1) and ram_wdata = byte; ram_we SHALL be 0 otherwise.
REQ-019 Back-to-back bytes on consecutive cycles SHALL be accepted without stall, one RAM write per byte.
REQ-020 After the N-th data byte the FSM SHALL go to CHECK (macro defined) or DONE (macro undefined); the address counter SHALL never wrap past N-1.
REQ-021 DONE: load_done=1 for exactly one cycle, cpu_halt cleared on that same cycle, then IDLE.
REQ-022 In COUNT, DATA or CHECK, TIMEOUT_CYCLES consecutive cycles without an accepted byte SHALL set load_error and return to IDLE; the timeout counter SHALL restart on every accepted byte.
REQ-023 On any error cpu_halt SHALL stay 1 (RAM possibly partial) until a later successful load or rst.
REQ-024 A HEADER byte received in COUNT, DATA or CHECK SHALL be treated as payload, not as a restart.

Reset
REQ-025 rst SHALL force IDLE, cpu_halt=0, load_done=0, load_error=0, ram_we=0, ram_addr=0, ram_wdata=0, counters=0, overriding any frame in progress; RAM contents SHALL be untouched.

Configuration
REQ-026 With LOADER_CHECKSUM_EN defined, CHECK SHALL accept one byte and compare it with the mod-256 sum of the N data bytes: equal -> DONE; unequal -> load_error, IDLE.
REQ-027 Without LOADER_CHECKSUM_EN, the CHECK state and checksum accumulator SHALL not be synthesised and DATA SHALL go directly to DONE.

Structure
REQ-028 Shared package cpu_pkg SHALL hold the state enum, HEADER default, RAM depth (16) and address width (4).
REQ-029 The timeout counter SHALL be a sub-module loader_timeout (enable, restart, expired).

Verification
REQ-030 A5, 03, 11, 22, 33 (macro off) -> writes addr0=11, addr1=22, addr2=33 on three cycles; load_done one pulse; cpu_halt 1->0.
REQ-031 A5, 02, 10, 20, 30 (macro on) -> two writes, load_done pulse; A5, 02, 10, 20, 31 -> load_error=1, no load_done, cpu_halt stays 1.
REQ-032 A5, 00 and A5, 11 -> load_error=1, no writes, IDLE.
REQ-033 A5, 04, 01, then no bytes for TIMEOUT_CYCLES (test value 20) -> load_error on cycle 20 after last accept, one write issued.
REQ-034 rst asserted after A5, 04, 01 -> all outputs 0, IDLE; following A5, 01, 7F loads addr0=7F.
REQ-035 Bytes 00, FF before A5 -> discarded, no writes, cpu_halt=0.
